// File: rtl/speed_cmd_sequencer.sv
// Turns level keyboard requests into spaced, one-hot, one-cycle rate commands with
// edge detection, auto-repeat, priority arbitration and divider clamping.
module speed_cmd_sequencer #(
    parameter logic [31:0] STEP          = 32'h10,
    parameter logic [31:0] MIN_DIV       = 32'h100,
    parameter logic [31:0] MAX_DIV       = 32'h1000,
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000,
    parameter int unsigned CNT_W         = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_up,
    input  logic        req_down,
    input  logic        req_reset,
    input  logic [31:0] cur_div,
    output logic        speed_up,
    output logic        speed_down,
    output logic        speed_reset,
    output logic        at_limit
);

    localparam logic [31:0]      UP_FLOOR      = MIN_DIV + STEP;
    localparam logic [31:0]      DOWN_CEIL     = MAX_DIV - STEP;
    localparam logic [CNT_W-1:0] DELAY_RELOAD  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_RELOAD = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic {IDLE, HOLD} state_t;
    // Encoding doubles as priority: a larger code beats a smaller one.
    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_UP   = 2'd1,
        CMD_DOWN = 2'd2,
        CMD_RST  = 2'd3
    } cmd_t;

    state_t           state_reg, state_next;
    cmd_t             active_reg, active_next;
    cmd_t             pending_reg, pending_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       req_q_reg;
    logic [2:0]       req;
    logic [2:0]       rise;
    logic             speed_up_reg, speed_down_reg, speed_reset_reg, at_limit_reg;
    logic             up_next, down_next, reset_next, at_limit_next;
    cmd_t             rise_cmd, cand_cmd, issue_cmd;
    logic             eligible;
    logic             active_level;

    assign req = {req_reset, req_down, req_up};

    for (genvar gi = 0; gi < 3; gi++) begin : g_edge
        assign rise[gi] = req[gi] & ~req_q_reg[gi];
    end

    function automatic cmd_t winner(input logic [2:0] v);
        if (v[2])      return CMD_RST;
        else if (v[1]) return CMD_DOWN;
        else if (v[0]) return CMD_UP;
        else           return CMD_NONE;
    endfunction

    always_comb begin
        case (active_reg)
            CMD_UP:   active_level = req_up;
            CMD_DOWN: active_level = req_down;
            CMD_RST:  active_level = req_reset;
            default:  active_level = 1'b0;
        endcase
    end

    assign eligible = ~(speed_up_reg | speed_down_reg | speed_reset_reg);
    assign rise_cmd = winner(rise);
    assign cand_cmd = (pending_reg > rise_cmd) ? pending_reg : rise_cmd;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            active_reg      <= CMD_NONE;
            pending_reg     <= CMD_NONE;
            cnt_reg         <= '0;
            req_q_reg       <= '0;
            speed_up_reg    <= 1'b0;
            speed_down_reg  <= 1'b0;
            speed_reset_reg <= 1'b0;
            at_limit_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            active_reg      <= active_next;
            pending_reg     <= pending_next;
            cnt_reg         <= cnt_next;
            req_q_reg       <= req;
            speed_up_reg    <= up_next;
            speed_down_reg  <= down_next;
            speed_reset_reg <= reset_next;
            at_limit_reg    <= at_limit_next;
        end
    end

    // Any new winning rise preempts the active key; while a pulse is high it waits in pending.
    always_comb begin
        state_next   = state_reg;
        active_next  = active_reg;
        pending_next = pending_reg;
        cnt_next     = cnt_reg;
        issue_cmd    = CMD_NONE;
        if (eligible) begin
            pending_next = CMD_NONE;
        end
        if (eligible && cand_cmd != CMD_NONE) begin
            issue_cmd   = cand_cmd;
            active_next = cand_cmd;
            if (cand_cmd == CMD_RST) begin
                state_next = IDLE;
                cnt_next   = '0;
            end else begin
                state_next = HOLD;
                cnt_next   = DELAY_RELOAD;
            end
        end else begin
            if (!eligible && rise_cmd != CMD_NONE) begin
                pending_next = cand_cmd;
            end
            if (state_reg == HOLD) begin
                if (!active_level) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == '0) begin
                    issue_cmd = active_reg;
                    cnt_next  = PERIOD_RELOAD;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        up_next       = 1'b0;
        down_next     = 1'b0;
        reset_next    = 1'b0;
        at_limit_next = at_limit_reg;
        case (issue_cmd)
            CMD_UP: begin
                if (cur_div >= UP_FLOOR) begin
                    up_next       = 1'b1;
                    at_limit_next = 1'b0;
                end else begin
                    at_limit_next = 1'b1;
                end
            end
            CMD_DOWN: begin
                if (cur_div <= DOWN_CEIL) begin
                    down_next     = 1'b1;
                    at_limit_next = 1'b0;
                end else begin
                    at_limit_next = 1'b1;
                end
            end
            CMD_RST: begin
                reset_next    = 1'b1;
                at_limit_next = 1'b0;
            end
            default: ;
        endcase
    end

    assign speed_up    = speed_up_reg;
    assign speed_down  = speed_down_reg;
    assign speed_reset = speed_reset_reg;
    assign at_limit    = at_limit_reg;

endmodule

// File: tb/tb_speed_cmd_sequencer.sv
// Bench for speed_cmd_sequencer: directed scenarios plus random key traffic, all compared
// against a timestamp-based reference model of the command rules.
module tb_speed_cmd_sequencer;

    localparam int DELAY  = 8;
    localparam int PERIOD = 4;
    localparam logic [31:0] UP_FLOOR  = 32'h110;
    localparam logic [31:0] DOWN_CEIL = 32'hFF0;

    logic        clk = 1'b0;
    logic        reset, req_up, req_down, req_reset;
    logic [31:0] cur_div;
    logic        speed_up, speed_down, speed_reset, at_limit;

    int n_checks = 0;
    int n_fail   = 0;

    speed_cmd_sequencer #(
        .STEP(32'h10), .MIN_DIV(32'h100), .MAX_DIV(32'h1000),
        .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset),
        .req_up(req_up), .req_down(req_down), .req_reset(req_reset),
        .cur_div(cur_div),
        .speed_up(speed_up), .speed_down(speed_down), .speed_reset(speed_reset),
        .at_limit(at_limit)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model. Keys: 0=up, 1=down, 2=reset; a higher index wins. -1 means none.
    // Repeat timing is tracked as the absolute edge number of the next due repeat.
    int m_prev[3];
    int m_hold, m_active, m_due, m_pend, m_pulse, m_lim, m_n;

    task automatic model_step(input int ku, input int kd, input int kr,
                              input logic [31:0] div, input int rs);
        int req[3];
        int win, cand, issue;
        bit busy;
        req = '{ku, kd, kr};
        if (rs != 0) begin
            m_prev = '{0, 0, 0};
            m_hold = 0; m_active = -1; m_due = 0; m_pend = -1; m_pulse = -1; m_lim = 0;
        end else begin
            win = -1;
            for (int i = 0; i < 3; i++) if (req[i] != 0 && m_prev[i] == 0) win = i;
            busy  = (m_pulse >= 0);
            cand  = (m_pend > win) ? m_pend : win;
            issue = -1;
            if (!busy) m_pend = -1;
            if (!busy && cand >= 0) begin
                issue    = cand;
                m_active = cand;
                m_hold   = (cand != 2);
                m_due    = m_n + DELAY;
            end else begin
                if (busy && win >= 0) m_pend = cand;
                if (m_hold != 0) begin
                    if (req[m_active] == 0) m_hold = 0;
                    else if (m_n == m_due) begin
                        issue = m_active;
                        m_due = m_n + PERIOD;
                    end
                end
            end
            m_pulse = -1;
            if (issue == 2) begin
                m_pulse = 2; m_lim = 0;
            end else if (issue == 1) begin
                if (div <= DOWN_CEIL) begin m_pulse = 1; m_lim = 0; end else m_lim = 1;
            end else if (issue == 0) begin
                if (div >= UP_FLOOR) begin m_pulse = 0; m_lim = 0; end else m_lim = 1;
            end
            m_prev = req;
        end
        m_n++;
    endtask

    // One clock: drive inputs, advance the model, then compare at the following negedge.
    task automatic step(input int ku, input int kd, input int kr,
                        input logic [31:0] div, input int rs);
        req_up    = (ku != 0);
        req_down  = (kd != 0);
        req_reset = (kr != 0);
        cur_div   = div;
        reset     = (rs != 0);
        model_step(ku, kd, kr, div, rs);
        @(negedge clk);
        check_val("speed_up",    {31'd0, speed_up},    {31'd0, m_pulse == 0});
        check_val("speed_down",  {31'd0, speed_down},  {31'd0, m_pulse == 1});
        check_val("speed_reset", {31'd0, speed_reset}, {31'd0, m_pulse == 2});
        check_val("at_limit",    {31'd0, at_limit},    m_lim);
        check_val("one_hot", 32'(speed_up) + 32'(speed_down) + 32'(speed_reset),
                  (m_pulse >= 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        logic [31:0] mask;
        int n_rst, n_other, ku, kd, kr;
        logic [31:0] divs [8];
        divs = '{32'h100, 32'h10F, 32'h110, 32'h470, 32'hFF0, 32'hFF1, 32'h1000, 32'h800};
        m_n = 0; m_pulse = -1; m_lim = 0;

        // Reset held with req_up high: press is seen right after release
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 32'h470, 1);
            check_val("t1_reset_up", {31'd0, speed_up}, 32'd0);
        end
        step(1, 0, 0, 32'h470, 0);
        check_val("t1_first_pulse", {31'd0, speed_up}, 32'd1);
        step(0, 0, 0, 32'h470, 0);
        check_val("t1_single_pulse", {31'd0, speed_up}, 32'd0);
        step(0, 0, 0, 32'h470, 0);

        // Held down key: pulses at 1, 9, 13, 17, nothing after release
        mask = '0;
        for (int k = 0; k < 30; k++) begin
            step((0), (k < 20) ? 1 : 0, 0, 32'h470, 0);
            if (speed_down) mask |= (32'd1 << k);
        end
        check_val("t2_repeat_times", mask, 32'h0001_1101);

        // Simultaneous rises: only reset, no repeats
        n_rst = 0; n_other = 0;
        for (int k = 0; k < 15; k++) begin
            step(1, 1, 1, 32'h470, 0);
            n_rst   += int'(speed_reset);
            n_other += int'(speed_up) + int'(speed_down);
        end
        check_val("t3_reset_count", n_rst, 32'd1);
        check_val("t3_other_count", n_other, 32'd0);
        step(0, 0, 0, 32'h470, 0);
        step(0, 0, 0, 32'h470, 0);

        // Clamp boundaries
        step(1, 0, 0, 32'h10F, 0);
        check_val("t4_up_clamped", {31'd0, speed_up}, 32'd0);
        check_val("t4_limit_set", {31'd0, at_limit}, 32'd1);
        step(0, 0, 0, 32'h10F, 0);
        step(1, 0, 0, 32'h470, 0);
        check_val("t4_up_ok", {31'd0, speed_up}, 32'd1);
        check_val("t4_limit_clr", {31'd0, at_limit}, 32'd0);
        step(0, 0, 0, 32'h470, 0);
        step(1, 0, 0, 32'h110, 0);
        check_val("t4_up_floor", {31'd0, speed_up}, 32'd1);
        step(0, 0, 0, 32'h110, 0);
        step(0, 1, 0, 32'hFF1, 0);
        check_val("t4_down_clamped", {31'd0, at_limit}, 32'd1);
        step(0, 0, 0, 32'hFF1, 0);
        step(0, 1, 0, 32'hFF0, 0);
        check_val("t4_down_ceil", {31'd0, speed_down}, 32'd1);
        step(0, 0, 0, 32'hFF0, 0);
        step(0, 0, 0, 32'hFF0, 0);

        // Down rises while an up pulse is high: deferred one idle cycle, then repeats
        step(1, 0, 0, 32'h470, 0);
        check_val("t5_up_pulse", {31'd0, speed_up}, 32'd1);
        step(1, 1, 0, 32'h470, 0);
        check_val("t5_gap", {31'd0, speed_up | speed_down}, 32'd0);
        step(1, 1, 0, 32'h470, 0);
        check_val("t5_down_pulse", {31'd0, speed_down}, 32'd1);
        mask = '0;
        for (int k = 1; k <= 8; k++) begin
            step(1, 1, 0, 32'h470, 0);
            if (speed_down) mask |= (32'd1 << k);
        end
        check_val("t5_down_repeat", mask, 32'h0000_0100);
        step(0, 0, 0, 32'h470, 0);
        step(0, 0, 0, 32'h470, 0);

        // Reset in the middle of a suppressed hold
        step(1, 0, 0, 32'h10F, 0);
        step(1, 0, 0, 32'h10F, 0);
        step(1, 0, 0, 32'h10F, 0);
        check_val("t6_limit_before", {31'd0, at_limit}, 32'd1);
        step(1, 0, 0, 32'h10F, 1);
        check_val("t6_limit_after", {31'd0, at_limit}, 32'd0);
        step(0, 0, 0, 32'h470, 0);

        // Random key traffic across boundary dividers
        ku = 0; kd = 0; kr = 0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 5) == 0) ku = 1 - ku;
            if ($urandom_range(0, 7) == 0) kd = 1 - kd;
            if ($urandom_range(0, 11) == 0) kr = 1 - kr;
            step(ku, kd, kr, divs[$urandom_range(0, 7)],
                 ($urandom_range(0, 99) == 0) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
